// File: rtl/pipe_register_chain.sv
// pipe_register_chain: DEPTH-stage chain of WIDTH-bit registers with a valid/ready handshake,
// global clock-enable and synchronous flush. Ready ripples combinationally from the output
// stage back to the input, so a full chain still streams one word per cycle.
// Optional occupancy counter port `occ` is built when PIPE_REGISTER_CHAIN_OCC_EN is defined.
module pipe_register_chain #(
  parameter int unsigned      WIDTH   = 7,
  parameter int unsigned      DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             qout
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`endif
);

  logic             go;
  logic             accept;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // en low or flush high blocks every movement in the chain.
  assign go = en & ~flush;

  // Stage k may advance if any stage above it is empty or the consumer takes the output word.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      adv[k] = go & room;
      room   = room | ~v_q[k];
    end
  end

  // Handshake outputs; qout deliberately ignores en so held data stays visible.
  assign in_ready  = go & (~v_q[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  assign out_valid = en & v_q[DEPTH-1];
  assign qout      = d_q[DEPTH-1];

  // Next state: walk from the output back so a downstream clear is overwritten by a refill.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (v_q[DEPTH-1] && adv[DEPTH-1]) begin
      v_d[DEPTH-1] = 1'b0;
    end
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      if (v_q[k] && adv[k]) begin
        v_d[k+1] = 1'b1;
        d_d[k+1] = d_q[k];
        v_d[k]   = 1'b0;
      end
    end
    if (accept) begin
      v_d[0] = 1'b1;
      d_d[0] = din;
    end
    // Flush drops every word but leaves the stale data in place.
    if (flush) begin
      v_d = '0;
    end
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= RST_VAL;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`ifdef PIPE_REGISTER_CHAIN_OCC_EN
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic            xfer;
  logic [OccW-1:0] occ_q, occ_d;

  assign xfer = v_q[DEPTH-1] & adv[DEPTH-1];

  // Occupancy tracks accepts minus output transfers; flush empties the chain.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !xfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (!accept && xfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_register_chain.sv
// Self-checking bench for pipe_register_chain (WIDTH=7, DEPTH=3, RST_VAL=7'h55).
// A negedge monitor keeps a scoreboard queue: accepted words are pushed, output transfers pop
// and compare. Scenario tasks add their own timing and handshake checks.
module tb_pipe_register_chain;

  localparam int unsigned W   = 7;
  localparam int unsigned D   = 3;
  localparam logic [W-1:0] RST = 7'h55;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] qout;
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
  logic [$clog2(D+1)-1:0] occ;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] exp_w;

  pipe_register_chain #(
    .WIDTH  (W),
    .DEPTH  (D),
    .RST_VAL(RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .qout     (qout)
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: handshakes are evaluated mid-cycle, committed by the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_order: got unexpected word %h, required no output", qout);
          end else begin
            exp_w = sb_q.pop_front();
            if (qout !== exp_w) begin
              miscompares++;
              $display("FAIL sb_data: got %h, required %h", qout, exp_w);
            end
          end
        end
        if (in_valid && in_ready) sb_q.push_back(din);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic drain();
    int n;
    @(posedge clk); #1;
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (n < 20 && (sb_q.size() != 0 || out_valid)) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending words out_valid=%b, required 0 and 0",
               sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || qout !== RST) begin
      miscompares++;
      $display("FAIL reset_init: got out_valid=%b qout=%h, required 0 and %h", out_valid, qout, RST);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      din = W'(8'h7A + i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || qout !== 7'h7A) begin
      miscompares++;
      $display("FAIL reset_prefill: got out_valid=%b qout=%h, required 1 and 7a", out_valid, qout);
    end
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || qout !== RST) begin
      miscompares++;
      $display("FAIL reset_mid: got out_valid=%b qout=%h, required 0 and %h", out_valid, qout, RST);
    end
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
    vectors++;
    if (occ !== '0) begin
      miscompares++;
      $display("FAIL reset_occ: got %0d, required 0", occ);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = 7'h12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_stream();
    int idx = 0, acc_c = -1, ov_first = -1, ov_last = -1, ov_cnt = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      in_valid = (idx < 10);
      din = W'(idx + 1);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (acc_c < 0) acc_c = c;
        idx++;
      end
      if (out_valid) begin
        if (ov_first < 0) ov_first = c;
        ov_last = c;
        ov_cnt++;
      end
    end
    vectors++;
    if (ov_first - acc_c !== 3) begin
      miscompares++;
      $display("FAIL stream_latency: got %0d cycles, required 3", ov_first - acc_c);
    end
    vectors++;
    if (ov_cnt !== 10 || ov_last - ov_first !== 9) begin
      miscompares++;
      $display("FAIL stream_contig: got %0d words over %0d cycles, required 10 over 10",
               ov_cnt, ov_last - ov_first + 1);
    end
    vectors++;
    if (idx !== 10) begin
      miscompares++;
      $display("FAIL stream_accepts: got %0d, required 10", idx);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      din = W'(idx + 1);
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_full_ready: got %b, required 0", in_ready);
        end
      end
      if (in_valid && in_ready) idx++;
    end
    vectors++;
    if (idx !== 3) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d, required 3", idx);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    din = 7'h04;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || qout !== 7'h01) begin
      miscompares++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b qout=%h, required 1 1 01",
               out_valid, in_ready, qout);
    end
    drain();
  endtask

  task automatic test_en_stall();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      din = W'(8'h11 * i);
    end
    @(posedge clk); #1;
    en = 1'b0;
    out_ready = 1'b1;
    din = 7'h44;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || qout !== 7'h11) begin
        miscompares++;
        $display("FAIL stall_hold: got out_valid=%b in_ready=%b qout=%h, required 0 0 11",
                 out_valid, in_ready, qout);
      end
      @(posedge clk); #1;
    end
    en = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || qout !== 7'h11) begin
      miscompares++;
      $display("FAIL stall_resume: got out_valid=%b qout=%h, required 1 and 11", out_valid, qout);
    end
    drain();
  endtask

  task automatic test_flush();
    int ov_first = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      din = W'(8'h21 + i);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    din = 7'h23;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_out_valid: got %b, required 0", out_valid);
    end
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
    vectors++;
    if (occ !== '0) begin
      miscompares++;
      $display("FAIL flush_occ: got %0d, required 0", occ);
    end
`endif
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid = (c == 0);
      din = 7'h3C;
      @(negedge clk);
      if (out_valid && ov_first < 0) begin
        ov_first = c;
        vectors++;
        if (qout !== 7'h3C) begin
          miscompares++;
          $display("FAIL flush_next_data: got %h, required 3c", qout);
        end
      end
    end
    vectors++;
    if (ov_first !== 3) begin
      miscompares++;
      $display("FAIL flush_next_latency: got %0d, required 3", ov_first);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
`ifdef PIPE_REGISTER_CHAIN_OCC_EN
      vectors++;
      if (occ !== sb_q.size() || occ > D) begin
        miscompares++;
        $display("FAIL occ_track: got %0d, required %0d", occ, sb_q.size());
      end
`endif
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      din = W'($urandom);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    din = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_en_stall();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
